// File: rtl/msj_receiver.sv
// msj bus consumer: stability filter, alarm latch, binary-to-BCD conversion
// and a multiplexed three-digit 7-segment display.
module msj_receiver #(
  parameter int STABLE_CYCLES = 4,
  parameter int REFRESH_DIV   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  msj,
  input  logic        ack,
  output logic [11:0] bcd,
  output logic        valid,
  output logic        alarm,
  output logic [3:0]  alarm_cnt,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = $clog2(REFRESH_DIV + 1);

  typedef enum logic [1:0] {
    IDLE, CONV, SHOW, ALARM
  } state_t;

  state_t state, nxt;

  logic [7:0]    p;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          is_ff;
  logic [19:0]   sh, sh_nxt, t;
  logic [2:0]    it;
  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic [6:0]    segv;

  assign accept = (msj == p) && (cnt == CW'(STABLE_CYCLES - 1));
  assign is_ff  = (msj == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      cnt <= '0;
    end else begin
      p <= msj;
      if (state == ALARM && ack)
        cnt <= '0;
      else if (msj != p)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, SHOW: begin
        if (accept) nxt = is_ff ? ALARM : CONV;
      end
      CONV: begin
        if (accept)         nxt = is_ff ? ALARM : CONV;
        else if (it == 3'd7) nxt = SHOW;
      end
      ALARM: begin
        if (ack) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == SHOW);
    alarm = (state == ALARM);
  end

  // One double-dabble step: add 3 to digits >= 5, then shift left.
  always_comb begin
    t = sh;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    sh_nxt = {t[18:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      it  <= '0;
      bcd <= '0;
    end else if (state != ALARM && accept && !is_ff) begin
      sh <= {12'd0, msj};
      it <= '0;
    end else if (state == CONV) begin
      sh <= sh_nxt;
      it <= it + 3'd1;
      if (it == 3'd7) bcd <= sh_nxt[19:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_cnt <= '0;
    end else if (nxt == ALARM && state != ALARM
                 && alarm_cnt != 4'd15) begin
      alarm_cnt <= alarm_cnt + 4'd1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    digit = bcd[3:0];
    unique case (1'b1)
      (idx == 2'd1): digit = bcd[7:4];
      (idx == 2'd2): digit = bcd[11:8];
      default:       digit = bcd[3:0];
    endcase
  end

  always_comb begin
    segv = 7'b1111111;
    unique case (1'b1)
      (state == ALARM):                  segv = 7'b0001110;
      (state == CONV || state == SHOW): segv = seg7(digit);
      default:                           segv = 7'b1111111;
    endcase
  end

  // seg/an are registered from the same idx, so every digit lags alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      an  <= 3'b110;
      seg <= 7'b1111111;
    end else begin
      if (div == DW'(REFRESH_DIV - 1)) begin
        div <= '0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      an  <= ~(3'b001 << idx);
      seg <= segv;
    end
  end

endmodule

// File: tb/tb_msj_receiver.sv
// Bench for msj_receiver: behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_msj_receiver;

  localparam int S = 4;
  localparam int R = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  msj = 8'd0;
  logic        ack = 1'b0;
  logic [11:0] bcd;
  logic        valid;
  logic        alarm;
  logic [3:0]  alarm_cnt;
  logic [6:0]  seg;
  logic [2:0]  an;

  always #5 clk = ~clk;

  msj_receiver #(.STABLE_CYCLES(S), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .msj(msj), .ack(ack),
    .bcd(bcd), .valid(valid), .alarm(alarm),
    .alarm_cnt(alarm_cnt), .seg(seg), .an(an)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: 0 idle, 1 converting, 2 showing, 3 alarm.
  int          ms;
  int          last, run, left, mval, acnt, tick;
  logic [11:0] mbcd;
  logic [6:0]  eseg;
  logic [2:0]  ean;
  bit          mready = 0;
  bit          saw200 = 0;

  function automatic logic [6:0] segcode(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] tobcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // run = number of consecutive edges the current value has been seen.
  task automatic model_step();
    int idx;
    bit accept;
    if (rst) begin
      ms = 0; last = 0; run = 1; mbcd = '0; acnt = 0; tick = 0;
      ean = 3'b110; eseg = 7'b1111111; mready = 1;
    end else begin
      idx = (tick / R) % 3;
      tick++;
      ean = ~(3'b001 << idx);
      if (ms == 3)      eseg = 7'b0001110;
      else if (ms == 0) eseg = 7'b1111111;
      else              eseg = segcode(int'(mbcd[4*idx +: 4]));
      accept = 0;
      if (msj == 8'(last)) begin
        if (run <= S) begin
          run++;
          accept = (run == S + 1);
        end
      end else begin
        run = 1;
      end
      last = int'(msj);
      if (ms == 3) begin
        if (ack) begin ms = 0; run = 1; end
      end else if (accept) begin
        if (msj == 8'hFF) begin
          ms = 3;
          if (acnt < 15) acnt++;
        end else begin
          ms = 1; mval = int'(msj); left = 8;
        end
      end else if (ms == 1) begin
        left--;
        if (left == 0) begin mbcd = tobcd(mval); ms = 2; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (valid && bcd == 12'h200) saw200 = 1;
    if (mready)
      chk("cycle", {4'd0, bcd, valid, alarm, alarm_cnt, seg, an},
          {4'd0, mbcd, ms == 2, ms == 3, 4'(acnt), eseg, ean});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] seen;
  logic [27:0] rstv;

  initial begin
    rstv = {12'h000, 1'b0, 1'b0, 4'd0, 7'b1111111, 3'b110};
    step(2);
    chk("reset", {bcd, valid, alarm, alarm_cnt, seg, an}, rstv);
    rst = 1'b0;
    step(11);
    chk("zero_not_yet", valid, 1'b0);
    step(1);
    chk("zero_valid", valid, 1'b1);
    chk("zero_bcd", bcd, 12'h000);

    msj = 8'd137;
    step(14);
    chk("b137", bcd, 12'h137);
    chk("v137", valid, 1'b1);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      case (an)
        3'b110: begin seen[0] = 1; chk("seg_u", seg, 7'b1111000); end
        3'b101: begin seen[1] = 1; chk("seg_t", seg, 7'b0110000); end
        3'b011: begin seen[2] = 1; chk("seg_h", seg, 7'b1111001); end
        default: chk("an_code", an, 3'b110);
      endcase
    end
    chk("an_cycle", seen, 3'b111);

    msj = 8'd5;
    step(3);
    msj = 8'd9;
    step(14);
    chk("b009", bcd, 12'h009);

    msj = 8'hFF;
    step(6);
    chk("alarm1", alarm, 1'b1);
    chk("acnt1", alarm_cnt, 4'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("seg_F", seg, 7'b0001110);
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("ack_low", alarm, 1'b0);
    step(3);
    chk("still_low", alarm, 1'b0);
    step(1);
    chk("realarm", alarm, 1'b1);
    chk("acnt2", alarm_cnt, 4'd2);

    msj = 8'd200;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(7);
    msj = 8'd10;
    step(5);
    chk("abort_valid", valid, 1'b0);
    step(9);
    chk("b010", bcd, 12'h010);
    chk("v010", valid, 1'b1);
    chk("no200", saw200, 1'b0);

    msj = 8'd77;
    step(7);
    rst = 1'b1;
    step(1);
    chk("rst_conv", {bcd, valid, alarm, alarm_cnt, seg, an}, rstv);
    rst = 1'b0;
    msj = 8'hFF;
    step(8);
    chk("alarm_after_rst", alarm, 1'b1);
    chk("acnt_after_rst", alarm_cnt, 4'd1);
    rst = 1'b1;
    step(1);
    chk("rst_alarm", {bcd, valid, alarm, alarm_cnt, seg, an}, rstv);
    rst = 1'b0;
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
